rca_adder_core: RTL and testbench

- Registered N-bit ripple-carry adder: the core block driven and checked through the team's rca_if interface bench.
- Inputs captured on a valid strobe, summed through a chain of 1-bit full adders, result registered with carry-out and signed-overflow flags.
- Fully pipelined, one result per cycle; used as the arithmetic leaf under test in the RCA verification environment.

---
 rtl/rca_pkg.sv | 23 ++
 rtl/rca_full_adder.sv | 16 +
 rtl/rca_adder_core.sv | 92 +++++++++
 tb/tb_rca_adder_core.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the registered ripple-carry adder: default width, result
// layout and a reference sum for bench use.
package rca_pkg;

    localparam int unsigned RCA_N = 4;
    localparam int unsigned RCA_MAX_N = 64;

    typedef struct packed {
        logic [RCA_N-1:0] s;
        logic             cout;
        logic             ovf;
    } rca_result_t;

    // Wide reference sum; bit 64 is the carry out of a 64-bit operand pair.
    function automatic logic [RCA_MAX_N:0] rca_ref_sum(
        input logic [RCA_MAX_N-1:0] a,
        input logic [RCA_MAX_N-1:0] b,
        input logic                 cin
    );
        return {1'b0, a} + {1'b0, b} + {{RCA_MAX_N{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/rca_full_adder.sv
// Single-bit full adder cell used as one link of the ripple chain.
module rca_full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/rca_adder_core.sv
// Registered N-bit ripple-carry adder: operand capture stage, full-adder chain, result
// stage with carry-out and signed-overflow flags. One result per cycle, 2-cycle latency.
module rca_adder_core
    import rca_pkg::*;
#(
    parameter int unsigned N = RCA_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf
);

    typedef struct packed {
        logic [N-1:0] s;
        logic         cout;
        logic         ovf;
    } result_t;

    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic         cin_q;
    logic         v1_q;

    logic [N:0]   c;
    logic [N-1:0] sum;

    result_t      res_d;
    result_t      res_q;
    logic         out_valid_q;

    // Operand regs only load on a valid strobe so idle inputs never toggle the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            v1_q  <= 1'b0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                a_q   <= a;
                b_q   <= b;
                cin_q <= cin;
            end
        end
    end

    assign c[0] = cin_q;

    for (genvar i = 0; i < N; i++) begin : g_bit
        rca_full_adder u_fa (
            .a  (a_q[i]),
            .b  (b_q[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end

    // Signed overflow: carry into the MSB differs from carry out of it (N=1 uses c[0]).
    always_comb begin
        res_d      = '0;
        res_d.s    = sum;
        res_d.cout = c[N];
        res_d.ovf  = c[N] ^ c[N-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= v1_q;
            if (v1_q) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign s         = res_q.s;
    assign cout      = res_q.cout;
    assign ovf       = res_q.ovf;

endmodule

// File: tb/tb_rca_adder_core.sv
// Self-checking bench for rca_adder_core (N=4): arithmetic reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_rca_adder_core;

    localparam int unsigned N = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         out_valid;
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;

    int checks;
    int failures;
    logic chk_en;
    logic [3:0] cov;

    rca_adder_core #(
        .N (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer arithmetic, unsigned for s/cout, signed range test for ovf.
    function automatic logic [5:0] model(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic ci);
        int total;
        int sx;
        int sy;
        int st;
        logic [N-1:0] sm;
        logic co;
        logic ov;
        total = int'(x) + int'(y) + int'(ci);
        sm = N'(total % 16);
        co = (total >= 16);
        sx = (x >= 8) ? int'(x) - 16 : int'(x);
        sy = (y >= 8) ? int'(y) - 16 : int'(y);
        st = sx + sy + int'(ci);
        ov = (st < -8) || (st > 7);
        return {sm, co, ov};
    endfunction

    // Model pipeline: result computed when operands are accepted, shown one edge later.
    logic       p_v;
    logic [5:0] p_r;
    logic       o_v;
    logic [5:0] o_r;

    always @(posedge clk) begin
        if (rst) begin
            p_v <= 1'b0;
            o_v <= 1'b0;
            o_r <= '0;
        end else begin
            p_v <= in_valid;
            if (in_valid) p_r <= model(a, b, cin);
            o_v <= p_v;
            if (p_v) o_r <= p_r;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ({out_valid, s, cout, ovf} !== {o_v, o_r}) begin
                failures++;
                $display("FAIL model t=%0t got v=%b s=%0d c=%b o=%b want v=%b s=%0d c=%b o=%b",
                         $time, out_valid, s, cout, ovf, o_v, o_r[5:2], o_r[1], o_r[0]);
            end
            if (o_v) cov[{o_r[1], o_r[0]}] = 1'b1;
        end
    end

    task automatic lit(input string name, input logic ev, input logic [N-1:0] es,
                       input logic ec, input logic eo);
        checks++;
        if ({out_valid, s, cout, ovf} !== {ev, es, ec, eo}) begin
            failures++;
            $display("FAIL %s got v=%b s=%0d c=%b o=%b want v=%b s=%0d c=%b o=%b",
                     name, out_valid, s, cout, ovf, ev, es, ec, eo);
        end
    endtask

    task automatic step(input logic [N-1:0] x, input logic [N-1:0] y, input logic ci);
        @(negedge clk);
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = ci;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        a = N'($urandom);
        b = N'($urandom);
        cin = 1'($urandom);
    endtask

    int order[512];

    initial begin
        checks = 0;
        failures = 0;
        chk_en = 1'b0;
        cov = '0;
        rst = 1'b1;
        in_valid = 1'b1;
        a = 4'hF;
        b = 4'h0;
        cin = 1'b0;

        // Reset held two cycles with valid inputs applied.
        @(negedge clk);
        chk_en = 1'b1;
        lit("reset_cycle0", 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        lit("reset_cycle1", 1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        lit("reset_release", 1'b0, 4'd0, 1'b0, 1'b0);

        step(4'd3, 4'd5, 1'b0);
        idle();
        idle();
        lit("3p5", 1'b1, 4'd8, 1'b0, 1'b1);

        step(4'd15, 4'd1, 1'b0);
        idle();
        idle();
        lit("15p1_wrap", 1'b1, 4'd0, 1'b1, 1'b0);
        idle();
        lit("hold_after_valid", 1'b0, 4'd0, 1'b1, 1'b0);

        step(4'd15, 4'd15, 1'b1);
        idle();
        idle();
        lit("15p15p1", 1'b1, 4'd15, 1'b1, 1'b0);

        // Back-to-back: results 2..5 on consecutive cycles.
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) step(N'(i), 4'd1, 1'b0);
            else idle();
            if (i >= 3) lit("back_to_back", 1'b1, N'(i - 1), 1'b0, 1'b0);
        end

        // Reset while one result is in stage 1 and another is being presented.
        step(4'd1, 4'd1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        a = 4'd2;
        b = 4'd2;
        cin = 1'b0;
        @(negedge clk);
        lit("midreset_flush", 1'b0, 4'd0, 1'b0, 1'b0);
        rst = 1'b0;
        in_valid = 1'b1;
        a = 4'd7;
        b = 4'd8;
        cin = 1'b1;
        idle();
        lit("midreset_gap", 1'b0, 4'd0, 1'b0, 1'b0);
        idle();
        lit("7p8p1", 1'b1, 4'd0, 1'b1, 1'b0);

        // Exhaustive 512 combinations, shuffled, back-to-back.
        for (int i = 0; i < 512; i++) order[i] = i;
        for (int i = 511; i > 0; i--) begin
            int j;
            int t;
            j = int'($urandom_range(i, 0));
            t = order[i];
            order[i] = order[j];
            order[j] = t;
        end
        for (int i = 0; i < 512; i++) begin
            int v;
            v = order[i];
            step(v[3:0], v[7:4], v[8]);
        end
        idle();
        idle();
        idle();

        checks++;
        if (cov !== 4'hF) begin
            failures++;
            $display("FAIL cout_ovf_cross got %b want 1111", cov);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
